// File: rtl/register_file.sv
// Register file: 2**ADDR_W entries of DATA_W bits, two combinational read ports
// and one synchronous write port. Entry 0 is hardwired to zero.
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle write data to a read
// port addressing the entry being written (write-before-read).
module register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic              wr_en;

  // Writes to entry 0 are dropped so it always reads as zero.
  assign wr_en = reg_write && (write_reg != '0);

  // Storage: asynchronous clear, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    read_data1 = regs_q[read_reg1];
    read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so that reads stay zero while reset is held.
    if (rst_n && wr_en && (read_reg1 == write_reg)) begin
      read_data1 = write_data;
    end
    if (rst_n && wr_en && (read_reg2 == write_reg)) begin
      read_data2 = write_data;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for register_file.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          clk_run = 1'b1;
  logic          rst_n = 1'b0;
  logic [AW-1:0] read_reg1 = '0;
  logic [AW-1:0] read_reg2 = '0;
  logic [AW-1:0] write_reg = '0;
  logic [DW-1:0] write_data = '0;
  logic          reg_write = 1'b0;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  register_file #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .reg_write (reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  // Clock can be parked low to prove reset acts without an edge.
  always #5 clk = clk_run ? ~clk : 1'b0;

  typedef struct {
    string         name;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model [N];
  int            checks = 0;
  int            errors = 0;
  event          sample_ev;

  // Architectural read rule: entry 0 is zero, otherwise stored value,
  // optionally overridden by a same-cycle enabled write.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] rr, input logic [AW-1:0] wr,
                                             input logic [DW-1:0] wd, input logic we);
    if (rr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if ((we === 1'b1) && (wr !== '0) && (wr === rr)) return wd;
`endif
    return model[rr];
  endfunction

  // Monitor: pops one expectation per sample and compares both ports.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: sample with no expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        checks++;
        if (read_data1 !== e.e1) begin
          errors++;
          $display("FAIL %s port1: got %h expected %h", e.name, read_data1, e.e1);
        end
        checks++;
        if (read_data2 !== e.e2) begin
          errors++;
          $display("FAIL %s port2: got %h expected %h", e.name, read_data2, e.e2);
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [AW-1:0] w, input logic [DW-1:0] d,
                      input logic we, input string nm);
    exp_t e;
    read_reg1  = r1;
    read_reg2  = r2;
    write_reg  = w;
    write_data = d;
    reg_write  = we;
    e.name = nm;
    e.e1   = ref_read(r1, w, d, we);
    e.e2   = ref_read(r2, w, d, we);
    q.push_back(e);
    #3;
    ->sample_ev;
    @(posedge clk);
    if ((we === 1'b1) && (w !== '0)) model[w] = d;
    #1;
  endtask

  task automatic sample_zero(input string nm);
    exp_t e;
    e.name = nm;
    e.e1   = '0;
    e.e2   = '0;
    q.push_back(e);
    #1;
    ->sample_ev;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] r1, r2, w;
    logic [DW-1:0] d, lost_d, first_d;
    logic          we;
    for (int i = 0; i < N; i++) model[i] = '0;

    // Reset state while rst_n is held from time 0.
    read_reg1 = 5'd1;
    read_reg2 = 5'd31;
    #12;
    sample_zero("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(5'd8, 5'd9, 5'd8, 32'hDEADBEEF, 1'b1, "wr8");
    step(5'd8, 5'd9, 5'd0, 32'h0, 1'b0, "rd8_rd9");
    step(5'd0, 5'd0, 5'd0, 32'h12345678, 1'b1, "wr0");
    step(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, "rd0");
    step(5'd0, 5'd0, 5'd5, 32'h00000011, 1'b1, "wr5");
    step(5'd5, 5'd5, 5'd5, 32'hFFFFFFFF, 1'b0, "en_off");
    step(5'd5, 5'd0, 5'd0, 32'h0, 1'b0, "keep5");
    step(5'd0, 5'd0, 5'd3, 32'h1, 1'b1, "wr3");
    step(5'd3, 5'd3, 5'd3, 32'h2, 1'b1, "hazard_pre");
    step(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, "hazard_post");
    step(5'd0, 5'd0, 5'd4, 32'hA, 1'b1, "wr4");
    step(5'd0, 5'd0, 5'd31, 32'hB, 1'b1, "wr31");
    step(5'd31, 5'd4, 5'd0, 32'h0, 1'b0, "dual");

    // Random traffic, including X write addresses with writes disabled.
    for (int i = 0; i < 400; i++) begin
      r1 = AW'($urandom_range(0, N - 1));
      r2 = ($urandom_range(0, 7) == 0) ? r1 : AW'($urandom_range(0, N - 1));
      w  = ($urandom_range(0, 3) == 0) ? r1 : AW'($urandom_range(0, N - 1));
      d  = $urandom;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        we = 1'b0;
        w  = 'x;
      end
      step(r1, r2, w, d, we, "random");
    end

    // Fill 1..31, then assert reset mid-cycle with the clock parked.
    for (int a = 1; a < N; a++) begin
      step(5'd0, 5'd0, AW'(a), $urandom, 1'b1, "fill");
    end
    clk_run = 1'b0;
    #6;
    lost_d     = $urandom | 32'h1;
    write_reg  = 5'd7;
    write_data = lost_d;
    reg_write  = 1'b1;
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) model[i] = '0;
    for (int a = 0; a < N; a++) begin
      read_reg1 = AW'(a);
      read_reg2 = AW'(N - 1 - a);
      sample_zero("reset_async");
    end

    // First write after release lands on the first rising edge.
    first_d    = $urandom | 32'h1;
    write_reg  = 5'd9;
    write_data = first_d;
    reg_write  = 1'b1;
    #1;
    rst_n   = 1'b1;
    clk_run = 1'b1;
    @(posedge clk);
    model[9] = first_d;
    #1;
    step(5'd9, 5'd7, 5'd0, 32'h0, 1'b0, "post_reset");

    for (int i = 0; i < 50; i++) begin
      step(AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)),
           AW'($urandom_range(0, N - 1)), $urandom, 1'($urandom_range(0, 1)), "random2");
    end

    #10;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of each register and of every data port.
REQ-002 The block SHALL have parameter ADDR_W, default 5: register address width, giving 2**ADDR_W entries.
REQ-003 Port clk: input, 1 bit; single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n: input, 1 bit; reset, asynchronous, active-low.
REQ-005 Port read_reg1: input, ADDR_W bits; read port 1 address (instruction rs field).
REQ-006 Port read_reg2: input, ADDR_W bits; read port 2 address (instruction rt field).
REQ-007 Port write_reg: input, ADDR_W bits; write address, driven by the upstream 5-bit destination mux (rt/rd select).
REQ-008 Port write_data: input, DATA_W bits; write data from the writeback stage.
REQ-009 Port reg_write: input, 1 bit; write enable from the control unit.
REQ-010 Port read_data1: output, DATA_W bits; contents addressed by read_reg1.
REQ-011 Port read_data2: output, DATA_W bits; contents addressed by read_reg2.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers of DATA_W bits.
REQ-013 Write: on a rising clk edge with reg_write=1 and write_reg!=0, entry[write_reg] SHALL take write_data; write latency is 1 cycle.
REQ-014 Writes with reg_write=0 SHALL leave all entries unchanged.
REQ-015 Writes with write_reg=0 SHALL be discarded; entry 0 SHALL always read as 0.
REQ-016 Reads SHALL be combinational: read_dataN reflects entry[read_regN] in the same cycle, with zero clock latency.
REQ-017 Both read ports SHALL operate independently, including read_reg1==read_reg2.
REQ-018 A same-cycle read and write to one address SHALL return the pre-edge value unless REGFILE_BYPASS_EN is defined (REQ-022).
REQ-019 Unknown (X) write_reg with reg_write=0 SHALL NOT corrupt any entry.

Reset
REQ-020 rst_n=0 SHALL clear all entries to 0 asynchronously, without waiting for a clock edge; read_data1 and read_data2 SHALL then read 0.
REQ-021 A write coinciding with asserted rst_n=0 SHALL be lost; the first write SHALL be accepted on the first rising edge after rst_n returns to 1.

Configuration
REQ-022 Macro REGFILE_BYPASS_EN defined: when reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN SHALL equal write_data combinationally in the same cycle (write-before-read).
REQ-023 Macro REGFILE_BYPASS_EN undefined: there SHALL be no bypass path; reads return stored contents only.

Verification
REQ-024 Reset: assert rst_n=0 mid-cycle after filling entries 1..31 -> read_data1 and read_data2 read 0 for every address, immediately without a clock edge.
REQ-025 Write/read: write 0xDEADBEEF to reg 8 -> next cycle read_reg1=8 gives 0xDEADBEEF; read_reg2=9 gives 0.
REQ-026 Zero register: write 0x12345678 to reg 0 -> read_reg1=0 gives 0x00000000.
REQ-027 Enable: reg_write=0 with write_reg=5 and write_data=0xFFFFFFFF -> reg 5 keeps its prior value 0x00000011.
REQ-028 Same-cycle hazard: reg 3 holds 0x1, write 0x2 to reg 3 with read_reg1=3 -> pre-edge read_data1 is 0x2 with REGFILE_BYPASS_EN and 0x1 without it; post-edge read_data1 is 0x2 in both builds.
REQ-029 Dual port: reg 4 holds 0xA and reg 31 holds 0xB -> read_reg1=31, read_reg2=4 give 0xB and 0xA in the same cycle.
